// File: rtl/boot_rom_pkg.sv
// Shared boot ROM definitions: image contents, default filler word, FSM states.
package boot_rom_pkg;

  localparam int unsigned BOOT_IMAGE_WORDS = 32;
  localparam logic [31:0] BOOT_NOP_WORD = 32'h6C00_0000;

  localparam logic [31:0] BOOT_IMAGE [0:BOOT_IMAGE_WORDS-1] = '{
    32'h2400_1F00, 32'h2401_1F04, 32'h2402_1F08, 32'h2403_1F0C,
    32'h8C04_0000, 32'h8C05_0004, 32'h8C06_0008, 32'h8C07_000C,
    32'h0085_4020, 32'h00C7_4820, 32'h0109_5020, 32'hAC0A_0010,
    32'h1140_0003, 32'h2108_FFFF, 32'h1500_FFFE, 32'h0000_0000,
    32'h3C0B_DEAD, 32'h356B_BEEF, 32'hAC0B_0014, 32'h2412_0020,
    32'h2413_0040, 32'h0253_A021, 32'hAC14_0018, 32'h0800_0040,
    32'h2414_0001, 32'h3C1D_0000, 32'h37BD_0FFC, 32'h0C00_0080,
    32'h0000_000C, 32'h4200_0018, 32'hFFFF_FFFF, 32'h0BAD_C0DE
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Image word lookup; indices past the stored table yield a recognisable pattern
  // so that larger IMAGE_DEPTH settings still elaborate.
  function automatic logic [31:0] boot_image_word(input logic [31:0] idx);
    if (idx < BOOT_IMAGE_WORDS) return BOOT_IMAGE[idx[4:0]];
    return {idx[15:0], 16'hA5A5};
  endfunction

endpackage

// File: rtl/boot_rom_array.sv
// Constant boot image with two independent registered read ports.
module boot_rom_array
  import boot_rom_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned IMAGE_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(BOOT_NOP_WORD)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  a_en,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  output logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_en,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_data
);

  function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [ADDR_WIDTH-1:0] addr);
    if (32'(addr) >= IMAGE_DEPTH) return NOP_WORD;
    return DATA_WIDTH'(boot_image_word(32'(addr)));
  endfunction

  // Each port loads only when enabled and otherwise holds its last word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_data <= '0;
      b_data <= '0;
    end else begin
      if (a_en) a_data <= rom_word(a_addr);
      if (b_en) b_data <= rom_word(b_addr);
    end
  end

endmodule

// File: rtl/boot_rom_streamer.sv
// Boot ROM with a random-read port and a ready/valid image streamer.
module boot_rom_streamer
  import boot_rom_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned IMAGE_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'(BOOT_NOP_WORD)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(IMAGE_DEPTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] index_q, base_q, next_idx, b_addr;
  logic                  accept_start, handshake, last_word, b_en;

  assign next_idx  = index_q + 1'b1;
  assign last_word = (index_q == LAST_IDX);
  assign out_addr  = base_q + index_q;

  // The stream word is prefetched: the ROM's second port is loaded with image[0]
  // on start and with image[index+1] on each non-final handshake, so out_data
  // is a register that naturally holds while the sink stalls.
  boot_rom_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IMAGE_DEPTH(IMAGE_DEPTH),
    .NOP_WORD   (NOP_WORD)
  ) u_rom (
    .clock  (clock),
    .reset_n(reset_n),
    .a_en   (rd_en),
    .a_addr (rd_addr),
    .a_data (rd_data),
    .b_en   (b_en),
    .b_addr (b_addr),
    .b_data (out_data)
  );

  // Random-read valid flag follows the request by one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rd_valid <= 1'b0;
    else          rd_valid <= rd_en;
  end

  // FSM state, stream index and latched destination base.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      index_q <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept_start) begin
        index_q <= '0;
        base_q  <= base_addr;
      end else if (handshake && !last_word) begin
        index_q <= next_idx;
      end
    end
  end

  // Next-state decode, handshake qualification (abort wins) and status outputs.
  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    handshake    = 1'b0;
    b_en         = 1'b0;
    b_addr       = next_idx;
    out_valid    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = STREAM;
          accept_start = 1'b1;
          b_en         = 1'b1;
          b_addr       = '0;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (abort) begin
          state_d = DONE;
        end else if (out_ready) begin
          handshake = 1'b1;
          if (last_word) state_d = DONE;
          else           b_en    = 1'b1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/boot_rom_streamer.md
BOOT_ROM_STREAMER -- requirements
Module: boot_rom_streamer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the instruction word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, meaning the width of both address ports.
REQ-003 The block SHALL have parameter IMAGE_DEPTH, default 32, meaning the number of ROM words (1..2^ADDR_WIDTH).
REQ-004 The block SHALL have parameter NOP_WORD, default 32'h6C00_0000, meaning the word returned for out-of-image reads.
REQ-005 The block SHALL have port clock, input, 1, the single clock; all logic SHALL be on posedge clock.
REQ-006 The block SHALL have port reset_n, input, 1; reset SHALL be asynchronous and active-low.
REQ-007 The block SHALL have port rd_en, input, 1, meaning random-read request.
REQ-008 The block SHALL have port rd_addr, input, ADDR_WIDTH, meaning random-read word address.
REQ-009 The block SHALL have port rd_data, output, DATA_WIDTH, meaning registered read data.
REQ-010 The block SHALL have port rd_valid, output, 1, meaning rd_data is valid this cycle.
REQ-011 The block SHALL have port start, input, 1, meaning a one-cycle request to stream the image.
REQ-012 The block SHALL have port abort, input, 1, meaning cancel the stream in progress.
REQ-013 The block SHALL have port base_addr, input, ADDR_WIDTH, meaning the destination base, sampled on accepted start.
REQ-014 The block SHALL have port out_valid, output, 1, meaning stream word offered.
REQ-015 The block SHALL have port out_ready, input, 1, meaning the sink accepts the stream word.
REQ-016 The block SHALL have port out_addr, output, ADDR_WIDTH, meaning the destination address of the offered word.
REQ-017 The block SHALL have port out_data, output, DATA_WIDTH, meaning the offered word.
REQ-018 The block SHALL have port busy, output, 1, meaning the FSM is in STREAM.
REQ-019 The block SHALL have port done, output, 1, meaning a one-cycle pulse when the stream completes or aborts.

Function
REQ-020 The image SHALL be constant (no runtime writes), IMAGE_DEPTH words, taken from the shared package.
REQ-021 The read port SHALL have 1-cycle latency: rd_en at cycle N gives rd_data/rd_valid at N+1; rd_valid=0 otherwise, with rd_data holding its last value.
REQ-022 A read with rd_addr >= IMAGE_DEPTH SHALL return NOP_WORD with rd_valid=1.
REQ-023 The FSM SHALL have states IDLE, STREAM, DONE.
REQ-024 IDLE->STREAM SHALL occur on start=1; the index is cleared to 0 and base_addr latched.
REQ-025 In STREAM, out_valid=1, out_data=image[index], out_addr=base+index (mod 2^ADDR_WIDTH wrap).
REQ-026 The handshake SHALL complete when out_valid&out_ready; index increments only then; out_data/out_addr SHALL be stable while out_valid=1 and out_ready=0.
REQ-027 Handshake on index=IMAGE_DEPTH-1 SHALL go to DONE.
REQ-028 abort=1 in STREAM SHALL go to DONE next cycle; abort takes priority over a same-cycle handshake (that word is not counted as transferred).
REQ-029 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-030 start in STREAM or DONE SHALL be ignored; abort in IDLE/DONE SHALL be ignored.
REQ-031 The read port and stream SHALL operate concurrently without interference.
REQ-032 out_valid, busy, and done SHALL be 0 outside STREAM and DONE respectively.

Reset
REQ-033 While reset_n=0: FSM=IDLE, index=0, latched base=0, rd_data=0, rd_valid=0, out_valid=0, out_addr=0, out_data=0, busy=0, done=0.
REQ-034 Reset mid-stream SHALL abandon the transfer without a done pulse.

Structure
REQ-035 Package boot_rom_pkg SHALL hold the image constant array, the default NOP_WORD, and the FSM state typedef.
REQ-036 One sub-module, boot_rom_array (registered dual-read ROM), is natural and SHALL hold the image storage.

Verification
REQ-037 Reads at address 0, then at IMAGE_DEPTH-1, then at 1000 -> image[0] and image[last] one cycle later each, then 32'h6C00_0000.
REQ-038 start with base_addr=0x100 and out_ready=1 -> 32 consecutive words at 0x100..0x11F, busy high 32 cycles, then done pulse once.
REQ-039 out_ready toggled randomly -> no word dropped or duplicated; data/address held while stalled.
REQ-040 base_addr=0x3F0 -> addresses wrap 0x3F0..0x3FF,0x000..0x00F.
REQ-041 abort together with a handshake at index 5 -> exactly 5 words transferred; done one cycle later; start while busy has no effect.
REQ-042 reset_n low at index 10 -> all outputs 0 immediately, no done pulse; a fresh start then streams from index 0.
